// File: rtl/mc68851_cir_if.sv
// CPU-side CIR bus bundle for the MC68851 coprocessor interface sequencer.
// The master drives the access strobe and data. The slave returns the registered Response CIR.
interface mc68851_cir_seq_if;
   logic        cs_i;
   logic        we_i;
   logic [4:0]  addr_i;
   logic [31:0] data_i;
   logic [15:0] resp_o;

   modport master (output cs_i, output we_i, output addr_i, output data_i, input resp_o);
   modport slave  (input cs_i, input we_i, input addr_i, input data_i, output resp_o);
endinterface

// File: rtl/mc68851_cir_seq.sv
// MC68851 CIR command sequencer: accepts a command, optionally collects one operand,
// hands it to the PMMU core, and reports progress through the Response CIR.
module mc68851_cir_seq #(
   parameter logic [15:0] RESP_NULL  = 16'h0802,
   parameter logic [15:0] RESP_BUSY  = 16'h8900,
   parameter logic [15:0] RESP_XFER  = 16'h8C04,
   parameter logic [15:0] RESP_PROTO = 16'h1C0E,
   parameter logic [7:0]  TIMEOUT    = 8'd255
) (
   input  logic                   clk_i,
   input  logic                   rst_n,
   mc68851_cir_seq_if.slave       bus,
   output logic [15:0]            cmd_o,
   output logic [31:0]            operand_o,
   output logic                   exec_req_o,
   input  logic                   exec_ack_i,
   output logic                   exec_abort_o,
   output logic                   busy_o,
   output logic [2:0]             o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECODE  = 3'd1,
      S_WAIT_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_PROTO   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_nxt;
   logic [7:0]  r_cnt;
   logic [15:0] r_resp;
   logic        w_ctrl_abort;
   logic        w_cmd_wr;
   logic        w_op_wr;
   logic        w_rsp_rd;
   logic        w_expire;
   logic        w_abort_pulse;

   assign w_ctrl_abort = bus.cs_i &&  bus.we_i && (bus.addr_i == 5'h00) && bus.data_i[15];
   assign w_cmd_wr     = bus.cs_i &&  bus.we_i && (bus.addr_i == 5'h08);
   assign w_op_wr      = bus.cs_i &&  bus.we_i && (bus.addr_i == 5'h10);
   assign w_rsp_rd     = bus.cs_i && !bus.we_i && (bus.addr_i == 5'h02);
   // r_cnt holds (EXEC cycles elapsed - 1), so expiry lands on the TIMEOUT-th EXEC cycle.
   assign w_expire     = (r_state == S_EXEC) && (r_cnt == TIMEOUT - 8'd1);

   function automatic logic [15:0] resp_for(state_t s);
      case (s)
         S_WAIT_OP: resp_for = RESP_XFER;
         S_EXEC:    resp_for = RESP_BUSY;
         S_PROTO:   resp_for = RESP_PROTO;
         default:   resp_for = RESP_NULL;
      endcase
   endfunction

   // Precedence: abort, ack, watchdog, protocol violation, then normal progress.
   always_comb begin
      w_nxt         = r_state;
      w_abort_pulse = 1'b0;
      if (w_ctrl_abort) begin
         w_nxt         = S_IDLE;
         w_abort_pulse = (r_state == S_EXEC);
      end else if ((r_state == S_EXEC) && exec_ack_i) begin
         w_nxt = S_IDLE;
      end else if (w_expire) begin
         w_nxt         = S_PROTO;
         w_abort_pulse = 1'b1;
      end else if (w_cmd_wr && (r_state != S_IDLE)) begin
         w_nxt         = S_PROTO;
         w_abort_pulse = (r_state == S_EXEC);
      end else begin
         case (r_state)
            S_IDLE:    if (w_cmd_wr) w_nxt = S_DECODE;
            S_DECODE:  w_nxt = cmd_o[15] ? S_WAIT_OP : S_EXEC;
            S_WAIT_OP: if (w_op_wr) w_nxt = S_EXEC;
            S_EXEC:    w_nxt = S_EXEC;
            S_PROTO:   if (w_rsp_rd) w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_resp       <= RESP_NULL;
         cmd_o        <= 16'd0;
         operand_o    <= 32'd0;
         exec_req_o   <= 1'b0;
         exec_abort_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         r_state      <= w_nxt;
         exec_abort_o <= w_abort_pulse;
         r_resp       <= resp_for(w_nxt);
         exec_req_o   <= (w_nxt == S_EXEC);
         busy_o       <= (w_nxt != S_IDLE);
         if ((r_state == S_IDLE) && (w_nxt == S_DECODE)) cmd_o <= bus.data_i[15:0];
         if ((r_state == S_WAIT_OP) && (w_nxt == S_EXEC)) operand_o <= bus.data_i;
         if ((r_state == S_EXEC) && (w_nxt == S_EXEC)) r_cnt <= r_cnt + 8'd1;
         else                                          r_cnt <= 8'd0;
      end
   end

   assign bus.resp_o  = r_resp;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc68851_cir_seq.sv
// Bench for mc68851_cir_seq: directed protocol scenarios plus random CIR traffic,
// compared cycle by cycle against a transaction-level model through an expected queue.
module tb_mc68851_cir_seq;
   localparam int W = 67;
   localparam logic [15:0] R_NULL  = 16'h0802;
   localparam logic [15:0] R_BUSY  = 16'h8900;
   localparam logic [15:0] R_XFER  = 16'h8C04;
   localparam logic [15:0] R_PROTO = 16'h1C0E;
   localparam int          TMO     = 255;

   // clock / reset
   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk_i = ~clk_i;

   mc68851_cir_seq_if bus();
   logic [15:0] cmd_o;
   logic [31:0] operand_o;
   logic        exec_req_o;
   logic        exec_ack_i;
   logic        exec_abort_o;
   logic        busy_o;
   logic [2:0]  dbg_state;

   mc68851_cir_seq dut (
      .clk_i        (clk_i),
      .rst_n        (rst_n),
      .bus          (bus),
      .cmd_o        (cmd_o),
      .operand_o    (operand_o),
      .exec_req_o   (exec_req_o),
      .exec_ack_i   (exec_ack_i),
      .exec_abort_o (exec_abort_o),
      .busy_o       (busy_o),
      .o_dbg_state  (dbg_state)
   );

   // scoreboard
   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   string tag = "reset";

   function automatic logic [W-1:0] act_snap();
      return {bus.resp_o, cmd_o, operand_o, exec_req_o, exec_abort_o, busy_o};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got resp=%h cmd=%h op=%h req=%b abort=%b busy=%b, expected resp=%h cmd=%h op=%h req=%b abort=%b busy=%b",
                  name, $time, act[66:51], act[50:35], act[34:3], act[2], act[1], act[0],
                  exp[66:51], exp[50:35], exp[34:3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) check(tag, act_snap(), exp_q.pop_front());
      end
   end

   // reference model: protocol phase plus how many EXEC cycles have already elapsed
   typedef enum int {P_IDLE, P_DECODE, P_WAIT, P_EXEC, P_PROTO} phase_t;
   phase_t      m_ph = P_IDLE;
   logic [15:0] m_cmd = '0;
   logic [31:0] m_op = '0;
   int          m_exec_n = 0;

   task automatic model_step(input logic cs, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic ack);
      logic   ab, cw, ow, rd, pulse;
      phase_t nx;
      logic [15:0] rsp;
      ab = cs && we && (addr == 5'h00) && data[15];
      cw = cs && we && (addr == 5'h08);
      ow = cs && we && (addr == 5'h10);
      rd = cs && !we && (addr == 5'h02);
      pulse = 1'b0;
      nx = m_ph;
      if (ab) begin
         pulse = (m_ph == P_EXEC);
         nx = P_IDLE;
      end else if (m_ph == P_EXEC && ack) begin
         nx = P_IDLE;
      end else if (m_ph == P_EXEC && (m_exec_n + 1 == TMO)) begin
         pulse = 1'b1;
         nx = P_PROTO;
      end else if (cw && m_ph != P_IDLE) begin
         pulse = (m_ph == P_EXEC);
         nx = P_PROTO;
      end else if (m_ph == P_IDLE && cw) begin
         m_cmd = data[15:0];
         nx = P_DECODE;
      end else if (m_ph == P_DECODE) begin
         nx = m_cmd[15] ? P_WAIT : P_EXEC;
      end else if (m_ph == P_WAIT && ow) begin
         m_op = data;
         nx = P_EXEC;
      end else if (m_ph == P_PROTO && rd) begin
         nx = P_IDLE;
      end
      m_exec_n = (nx == P_EXEC && m_ph == P_EXEC) ? m_exec_n + 1 : 0;
      m_ph = nx;
      case (m_ph)
         P_WAIT:  rsp = R_XFER;
         P_EXEC:  rsp = R_BUSY;
         P_PROTO: rsp = R_PROTO;
         default: rsp = R_NULL;
      endcase
      exp_q.push_back({rsp, m_cmd, m_op, (m_ph == P_EXEC), pulse, (m_ph != P_IDLE)});
   endtask

   // drivers
   task automatic step(input logic cs, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic ack);
      @(negedge clk_i);
      bus.cs_i   = cs;
      bus.we_i   = we;
      bus.addr_i = addr;
      bus.data_i = data;
      exec_ack_i = ack;
      model_step(cs, we, addr, data, ack);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h00, 32'h0, 1'b0);
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      step(1'b1, 1'b1, addr, data, 1'b0);
   endtask

   task automatic rd_resp();
      step(1'b1, 1'b0, 5'h02, 32'h0, 1'b0);
   endtask

   task automatic drain();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; exec_ack_i = 1'b0;
      #12;
      check("reset_state", act_snap(), {R_NULL, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0});
      @(negedge clk_i);
      rst_n = 1'b1;

      tag = "cmd_no_operand_ack";
      wr(5'h08, 32'h0000_0012);
      idle(2);
      step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1);
      idle(2);

      tag = "cmd_with_operand";
      wr(5'h08, 32'h0000_8040);
      idle(2);
      wr(5'h10, 32'hDEAD_BEEF);
      idle(3);
      step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1);
      idle(1);

      tag = "watchdog_timeout";
      wr(5'h08, 32'h0000_0001);
      idle(TMO + 4);
      rd_resp();
      idle(2);

      tag = "cmd_during_wait_op";
      wr(5'h08, 32'h0000_8040);
      idle(2);
      wr(5'h08, 32'h0000_1234);
      idle(2);
      rd_resp();
      idle(1);

      tag = "abort_with_ack";
      wr(5'h08, 32'h0000_0012);
      idle(3);
      step(1'b1, 1'b1, 5'h00, 32'h0000_8000, 1'b1);
      idle(2);

      tag = "stray_operand_ack";
      wr(5'h10, 32'h1111_2222);
      step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1);
      wr(5'h00, 32'h0000_7FFF);
      rd_resp();
      wr(5'h08, 32'h0000_0034);
      wr(5'h08, 32'h0000_0056);
      idle(1);
      rd_resp();
      idle(1);

      tag = "random";
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] d;
         logic        ack;
         int          kind;
         d    = $urandom;
         ack  = ($urandom_range(0, 5) == 0);
         kind = $urandom_range(0, 9);
         case (kind)
            2: step(1'b1, 1'b1, 5'h08, d, ack);
            3: step(1'b1, 1'b1, 5'h10, d, ack);
            4: step(1'b1, 1'b1, 5'h00, {d[31:16], ($urandom_range(0, 3) == 0), d[14:0]}, ack);
            5: step(1'b1, 1'b0, 5'h02, d, ack);
            6: step(1'b1, d[5], d[4:0], d, ack);
            default: step(1'b0, 1'b0, 5'h00, d, ack);
         endcase
      end
      idle(1);

      tag = "async_reset_in_exec";
      wr(5'h08, 32'h0000_0012);
      idle(3);
      drain();
      rst_n = 1'b0;
      #1;
      check("async_reset_in_exec", act_snap(), {R_NULL, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0});
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_hold_no_abort", act_snap(), {R_NULL, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0});
      m_ph = P_IDLE; m_cmd = '0; m_op = '0; m_exec_n = 0;
      @(negedge clk_i);
      rst_n = 1'b1;

      tag = "after_reset";
      wr(5'h08, 32'h0000_8077);
      idle(1);
      wr(5'h10, 32'hCAFE_F00D);
      step(1'b0, 1'b0, 5'h00, 32'h0, 1'b1);
      idle(2);
      drain();

      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mc68851_cir_seq.md
MC68851_CIR_SEQ -- requirements
Module: mc68851_cir_seq

Interface
REQ-001 SHALL have parameter RESP_NULL, default 16'h0802, the response value when idle or done.
REQ-002 SHALL have parameter RESP_BUSY, default 16'h8900, the response value while a command executes.
REQ-003 SHALL have parameter RESP_XFER, default 16'h8C04, the response value requesting a 4-byte operand from the CPU.
REQ-004 SHALL have parameter RESP_PROTO, default 16'h1C0E, the response value after a protocol violation.
REQ-005 SHALL have parameter TIMEOUT, default 8'd255, the maximum number of EXEC cycles before a watchdog abort.
REQ-006 SHALL have ports:
  clk_i  in  1  sole clock; all state updates on its rising edge
  rst_n  in  1  asynchronous, active-low reset
  cs_i  in  1  CIR access strobe, one cycle per access
  we_i  in  1  1 = write, 0 = read; qualified by cs_i
  addr_i  in  5  CIR byte offset
  data_i  in  32  write data
  resp_o  out  16  current Response CIR value
  cmd_o  out  16  latched command word
  operand_o  out  32  latched operand
  exec_req_o  out  1  execution request to the PMMU core
  exec_ack_i  in  1  core completion, single-cycle pulse
  exec_abort_o  out  1  single-cycle abort pulse to the core
  busy_o  out  1  high in every state except IDLE

Function
REQ-007 SHALL decode a write at 5'h00 as CONTROL, 5'h08 as COMMAND (data_i[15:0]) and 5'h10 as OPERAND (data_i[31:0]), and a read at 5'h02 as RESPONSE; all other accesses SHALL have no effect.
REQ-008 SHALL implement states IDLE, DECODE, WAIT_OP, EXEC and PROTO.
REQ-009 IDLE: resp_o=RESP_NULL; a COMMAND write SHALL latch cmd_o and move to DECODE on the next edge.
REQ-010 DECODE SHALL last exactly one cycle: if cmd_o[15]=1, go to WAIT_OP; otherwise go to EXEC.
REQ-011 WAIT_OP: resp_o=RESP_XFER; an OPERAND write SHALL latch operand_o and move to EXEC.
REQ-012 EXEC: resp_o=RESP_BUSY and exec_req_o=1; the watchdog counter SHALL clear on entry and increment each cycle.
REQ-013 EXEC: exec_ack_i=1 SHALL return the block to IDLE, with exec_req_o=0 in the following cycle.
REQ-014 EXEC: if the counter reaches TIMEOUT without an ack, the block SHALL pulse exec_abort_o for one cycle and go to PROTO.
REQ-015 A COMMAND write in any state other than IDLE SHALL go to PROTO without changing cmd_o; if the state was EXEC, exec_abort_o SHALL also pulse.
REQ-016 PROTO: resp_o=RESP_PROTO; a RESPONSE read SHALL return RESP_PROTO in that cycle and then go to IDLE.
REQ-017 A CONTROL write with data_i[15]=1 (abort) SHALL go to IDLE from any state and pulse exec_abort_o when the state was EXEC.
REQ-018 Precedence within one cycle SHALL be: CONTROL abort, then exec_ack_i, then watchdog expiry, then protocol violation.
REQ-019 An abort and exec_ack_i in the same cycle SHALL still produce the abort pulse; the ack SHALL be discarded.
REQ-020 An OPERAND write outside WAIT_OP SHALL be ignored and SHALL NOT be treated as a violation.
REQ-021 exec_ack_i outside EXEC SHALL be ignored.
REQ-022 resp_o, exec_req_o and busy_o SHALL be registered outputs that depend only on the current state.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, resp_o=RESP_NULL, cmd_o=0, operand_o=0, exec_req_o=0, exec_abort_o=0, busy_o=0 and the counter to 0.
REQ-024 Reset asserted during EXEC SHALL drop exec_req_o without waiting for a clock edge and SHALL NOT pulse exec_abort_o.

Verification
REQ-025 COMMAND 16'h0012 -> DECODE for 1 cycle, then EXEC with resp_o=16'h8900 and cmd_o=16'h0012; ack on the 3rd EXEC cycle -> IDLE, resp_o=16'h0802.
REQ-026 COMMAND 16'h8040 -> resp_o=16'h8C04; OPERAND 32'hDEADBEEF -> operand_o=32'hDEADBEEF, EXEC, exec_req_o=1.
REQ-027 EXEC with no ack -> after 255 cycles, one exec_abort_o pulse and resp_o=16'h1C0E; RESPONSE read -> IDLE.
REQ-028 Second COMMAND during WAIT_OP -> PROTO, cmd_o unchanged, no abort pulse.
REQ-029 CONTROL 32'h00008000 in the same cycle as exec_ack_i -> one abort pulse, IDLE.
REQ-030 rst_n low mid-EXEC -> exec_req_o=0 asynchronously, all outputs at reset values, no abort pulse.
